// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle control FSM and its decoder.
package mc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_WRITEBACK
  } state_e;

  typedef enum logic [3:0] {
    ALU_NOP  = 4'd0,
    ALU_ADD  = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_AND  = 4'd3,
    ALU_OR   = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_MOV  = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_ROTR = 4'd9
  } alu_op_e;

  // Immediate source selection
  localparam logic [1:0] IMM_REG  = 2'd0;
  localparam logic [1:0] IMM_ZE15 = 2'd1;
  localparam logic [1:0] IMM_SE15 = 2'd2;
  localparam logic [1:0] IMM_SE20 = 2'd3;

  // Primary opcodes, IR[30:25]
  localparam logic [5:0] OP_MOVI = 6'b100010;
  localparam logic [5:0] OP_ADDI = 6'b101000;
  localparam logic [5:0] OP_ORI  = 6'b101100;
  localparam logic [5:0] OP_XORI = 6'b101011;
  localparam logic [5:0] OP_ALU1 = 6'b100000;

  // ALU_1 sub-ops, IR[4:0]
  localparam logic [4:0] SUB_ADD   = 5'b00000;
  localparam logic [4:0] SUB_SUB   = 5'b00001;
  localparam logic [4:0] SUB_AND   = 5'b00010;
  localparam logic [4:0] SUB_XOR   = 5'b00011;
  localparam logic [4:0] SUB_OR    = 5'b00100;
  localparam logic [4:0] SUB_SLLI  = 5'b01000;
  localparam logic [4:0] SUB_SRLI  = 5'b01001;
  localparam logic [4:0] SUB_ROTRI = 5'b01011;

endpackage

// File: rtl/mc_decoder.sv
// Combinational instruction decoder: IR -> ALU/regfile control and immediate.
module mc_decoder
  import mc_pkg::*;
#(
  parameter int DataSize = 32
) (
  input  logic [DataSize-1:0] ir_i,
  output alu_op_e             alu_op_o,
  output logic [1:0]          imm_sel_o,
  output logic [4:0]          rd_o,
  output logic [4:0]          ra_o,
  output logic [4:0]          rb_o,
  output logic [DataSize-1:0] imm_o,
  output logic                legal_o,
  output logic                writes_o
);

  logic [5:0] opcode;
  logic [4:0] subop;
  logic       unused_bits;

  assign opcode      = ir_i[30:25];
  assign subop       = ir_i[4:0];
  assign rd_o        = ir_i[24:20];
  assign ra_o        = ir_i[19:15];
  assign rb_o        = ir_i[14:10];
  assign unused_bits = ^{ir_i[DataSize-1:31], ir_i[9:5]};

  // Opcode/sub-op decode and immediate extension
  always_comb begin
    alu_op_o  = ALU_NOP;
    imm_sel_o = IMM_REG;
    legal_o   = 1'b1;
    case (opcode)
      OP_MOVI: begin alu_op_o = ALU_MOV; imm_sel_o = IMM_SE20; end
      OP_ADDI: begin alu_op_o = ALU_ADD; imm_sel_o = IMM_SE15; end
      OP_ORI:  begin alu_op_o = ALU_OR;  imm_sel_o = IMM_ZE15; end
      OP_XORI: begin alu_op_o = ALU_XOR; imm_sel_o = IMM_ZE15; end
      OP_ALU1: begin
        case (subop)
          SUB_ADD:   alu_op_o = ALU_ADD;
          SUB_SUB:   alu_op_o = ALU_SUB;
          SUB_AND:   alu_op_o = ALU_AND;
          SUB_XOR:   alu_op_o = ALU_XOR;
          SUB_OR:    alu_op_o = ALU_OR;
          SUB_SLLI:  alu_op_o = ALU_SLL;
          // SRLI R0,R0,0 is the canonical NOP encoding
          SUB_SRLI:  alu_op_o = (ir_i[24:10] == '0) ? ALU_NOP : ALU_SRL;
          SUB_ROTRI: alu_op_o = ALU_ROTR;
          default:   legal_o  = 1'b0;
        endcase
      end
      default: legal_o = 1'b0;
    endcase

    case (imm_sel_o)
      IMM_ZE15: imm_o = {{(DataSize-15){1'b0}}, ir_i[14:0]};
      IMM_SE15: imm_o = {{(DataSize-15){ir_i[14]}}, ir_i[14:0]};
      IMM_SE20: imm_o = {{(DataSize-20){ir_i[19]}}, ir_i[19:0]};
      default:  imm_o = '0;
    endcase

    writes_o = legal_o && (alu_op_o != ALU_NOP);
  end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle control FSM: sequences FETCH/DECODE/EXECUTE/WRITEBACK, owns PC and IR.
module mc_controller
  import mc_pkg::*;
#(
  parameter int DataSize = 32,
  parameter int MemSize  = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic [DataSize-1:0] instruction,
  output logic [MemSize-1:0]  PC,
  output logic                IM_read,
  output logic                IM_write,
  output logic                IM_enable,
  output logic                rf_read,
  output logic                alu_en,
  output logic                rf_write,
  output logic [3:0]          alu_op,
  output logic [1:0]          imm_sel,
  output logic [4:0]          rd,
  output logic [4:0]          ra,
  output logic [4:0]          rb,
  output logic [DataSize-1:0] imm,
  output logic                illegal
);

  state_e              state_q;
  logic [MemSize-1:0]  pc_q;
  logic [MemSize-1:0]  pc_d;
  logic [DataSize-1:0] ir_q;
  logic                fetch_q;
  logic                decode_q;
  logic                exec_q;
  logic                wb_q;
  alu_op_e             dec_alu_op;
  logic                dec_legal;
  logic                dec_writes;

  assign pc_d = pc_q + 1'b1;

  // State, PC, IR and per-state strobe flags; everything holds while stalled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      ir_q     <= '0;
      fetch_q  <= 1'b0;
      decode_q <= 1'b0;
      exec_q   <= 1'b0;
      wb_q     <= 1'b0;
    end else if (!stall) begin
      case (state_q)
        ST_IDLE: begin
          state_q <= ST_FETCH;
          fetch_q <= 1'b1;
        end
        ST_FETCH: begin
          state_q  <= ST_DECODE;
          fetch_q  <= 1'b0;
          decode_q <= 1'b1;
        end
        ST_DECODE: begin
          state_q  <= ST_EXECUTE;
          ir_q     <= instruction;
          decode_q <= 1'b0;
          exec_q   <= 1'b1;
        end
        ST_EXECUTE: begin
          state_q <= ST_WRITEBACK;
          exec_q  <= 1'b0;
          wb_q    <= 1'b1;
        end
        ST_WRITEBACK: begin
          state_q <= ST_FETCH;
          pc_q    <= pc_d;
          wb_q    <= 1'b0;
          fetch_q <= 1'b1;
        end
        default: begin
          state_q  <= ST_IDLE;
          fetch_q  <= 1'b0;
          decode_q <= 1'b0;
          exec_q   <= 1'b0;
          wb_q     <= 1'b0;
        end
      endcase
    end
  end

  mc_decoder #(.DataSize(DataSize)) u_decoder (
    .ir_i      (ir_q),
    .alu_op_o  (dec_alu_op),
    .imm_sel_o (imm_sel),
    .rd_o      (rd),
    .ra_o      (ra),
    .rb_o      (rb),
    .imm_o     (imm),
    .legal_o   (dec_legal),
    .writes_o  (dec_writes)
  );

  // Stall masks the registered strobes in the same cycle: a state's strobe is
  // seen only in the cycle that state actually advances, so each fires once.
  assign PC        = pc_q;
  assign IM_write  = 1'b0;
  assign IM_read   = fetch_q  & ~stall;
  assign IM_enable = fetch_q  & ~stall;
  assign rf_read   = decode_q & ~stall;
  assign alu_en    = exec_q   & ~stall;
  assign illegal   = exec_q   & ~stall & ~dec_legal;
  assign rf_write  = wb_q     & ~stall & dec_writes;
  assign alu_op    = dec_alu_op;

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: table-driven instruction vectors
// plus directed stall, reset and PC-wrap sequences.
module tb_mc_controller;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [31:0] instruction;
  logic [9:0]  PC;
  logic        IM_read, IM_write, IM_enable;
  logic        rf_read, alu_en, rf_write, illegal;
  logic [3:0]  alu_op;
  logic [1:0]  imm_sel;
  logic [4:0]  rd, ra, rb;
  logic [31:0] imm;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  rd, ra, rb;
    logic [3:0]  op;
    logic [1:0]  sel;
    logic [31:0] imm;
    logic        wr;
    logic        ill;
  } vec_t;

  vec_t        tbl [9];
  vec_t        nop_rec;
  logic [31:0] mem [1024];

  mc_controller #(.DataSize(32), .MemSize(10)) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .instruction (instruction),
    .PC          (PC),
    .IM_read     (IM_read),
    .IM_write    (IM_write),
    .IM_enable   (IM_enable),
    .rf_read     (rf_read),
    .alu_en      (alu_en),
    .rf_write    (rf_write),
    .alu_op      (alu_op),
    .imm_sel     (imm_sel),
    .rd          (rd),
    .ra          (ra),
    .rb          (rb),
    .imm         (imm),
    .illegal     (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction memory model
  always @(posedge clk) begin
    if (IM_enable && IM_read) instruction <= mem[PC];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_im_read"},  IM_read,  1'b0);
    chk({tag, "_rf_read"},  rf_read,  1'b0);
    chk({tag, "_alu_en"},   alu_en,   1'b0);
    chk({tag, "_rf_write"}, rf_write, 1'b0);
    chk({tag, "_illegal"},  illegal,  1'b0);
  endtask

  // Runs one unstalled instruction; entered at the negedge inside FETCH
  task automatic run_instr(input vec_t v, input int pc);
    chk("f_pc",        PC,        pc[9:0]);
    chk("f_im_read",   IM_read,   1'b1);
    chk("f_im_enable", IM_enable, 1'b1);
    chk("f_im_write",  IM_write,  1'b0);
    chk("f_rf_read",   rf_read,   1'b0);
    @(negedge clk);
    chk("d_rf_read",   rf_read,   1'b1);
    chk("d_im_read",   IM_read,   1'b0);
    chk("d_alu_en",    alu_en,    1'b0);
    @(negedge clk);
    chk("e_alu_en",    alu_en,    1'b1);
    chk("e_illegal",   illegal,   v.ill);
    chk("e_rf_write",  rf_write,  1'b0);
    chk("e_rd",        rd,        v.rd);
    chk("e_ra",        ra,        v.ra);
    chk("e_rb",        rb,        v.rb);
    chk("e_alu_op",    alu_op,    v.op);
    chk("e_imm_sel",   imm_sel,   v.sel);
    chk("e_imm",       imm,       v.imm);
    @(negedge clk);
    chk("w_rf_write",  rf_write,  v.wr);
    chk("w_alu_en",    alu_en,    1'b0);
    chk("w_illegal",   illegal,   1'b0);
    chk("w_pc",        PC,        pc[9:0]);
    @(negedge clk);
  endtask

  initial begin
    //            instr         rd  ra  rb  op  sel imm           wr ill
    tbl[0] = '{32'h44000004,  0,  0,  0,  6, 3, 32'h00000004, 1, 0}; // MOVI R0,4
    tbl[1] = '{32'h5000000D,  0,  0,  0,  1, 2, 32'h0000000D, 1, 0}; // ADDI R0,R0,13
    tbl[2] = '{32'h40100400,  1,  0,  1,  1, 0, 32'h00000000, 1, 0}; // ADD R1,R0,R1
    tbl[3] = '{32'h40000009,  0,  0,  0,  0, 0, 32'h00000000, 0, 0}; // NOP
    tbl[4] = '{32'h7E000000,  0,  0,  0,  0, 0, 32'h00000000, 0, 1}; // unknown opcode
    tbl[5] = '{32'h50537FFF,  5,  6, 31,  1, 2, 32'hFFFFFFFF, 1, 0}; // ADDI R5,R6,-1
    tbl[6] = '{32'h40740C08,  7,  8,  3,  7, 0, 32'h00000000, 1, 0}; // SLLI R7,R8,3
    tbl[7] = '{32'h40000005,  0,  0,  0,  0, 0, 32'h00000000, 0, 1}; // unknown sub-op
    tbl[8] = '{32'h45FFFFFF, 31, 31, 31,  6, 3, 32'hFFFFFFFF, 1, 0}; // MOVI R31,-1
    nop_rec = tbl[3];

    for (int i = 0; i < 1024; i++) mem[i] = 32'h40000009;
    for (int i = 0; i < 9; i++) mem[i] = tbl[i].instr;
    mem[9] = 32'h5821C001; // ORI R2,R3,0x4001

    reset = 1'b1;
    stall = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pc", PC, 10'd0);
    chk("rst_alu_op", alu_op, 4'd0);
    chk("rst_imm_sel", imm_sel, 2'd0);
    chk_quiet("rst");

    // One cycle of IDLE after release, then FETCH of word 0
    reset = 1'b0;
    #1;
    chk("idle_im_read", IM_read, 1'b0);
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_instr(tbl[i], i);

    // Stall five cycles in DECODE of ORI at PC 9
    chk("s_pc", PC, 10'd9);
    chk("s_im_read", IM_read, 1'b1);
    @(negedge clk);
    stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk_quiet("sd");
      chk("sd_pc", PC, 10'd9);
      chk("sd_rd_hold", rd, 5'd31);
      @(negedge clk);
    end
    stall = 1'b0;
    #1;
    chk("sd_rel_rf_read", rf_read, 1'b1);
    chk("sd_rel_rd_hold", rd, 5'd31);
    @(negedge clk);
    chk("se_alu_en", alu_en, 1'b1);
    chk("se_rd", rd, 5'd2);
    chk("se_ra", ra, 5'd3);
    chk("se_rb", rb, 5'd16);
    chk("se_alu_op", alu_op, 4'd4);
    chk("se_imm_sel", imm_sel, 2'd1);
    chk("se_imm", imm, 32'h00004001);
    @(negedge clk);
    chk("sw_rf_write", rf_write, 1'b1);
    @(negedge clk);

    // Stall two cycles in FETCH at PC 10: fetch withheld, then re-issued
    stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("sf_im_read", IM_read, 1'b0);
      chk("sf_im_enable", IM_enable, 1'b0);
      chk("sf_pc", PC, 10'd10);
      @(negedge clk);
    end
    stall = 1'b0;
    #1;
    run_instr(nop_rec, 10);

    // Reset asserted mid-EXECUTE of the instruction at PC 11
    chk("r_pc", PC, 10'd11);
    @(negedge clk);
    @(negedge clk);
    chk("r_alu_en_pre", alu_en, 1'b1);
    reset = 1'b1;
    #1;
    chk("r_pc0", PC, 10'd0);
    chk("r_alu_op", alu_op, 4'd0);
    chk_quiet("r_async");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk_quiet("r_hold");
    end
    reset = 1'b0;
    #1;
    chk("r_idle_im_read", IM_read, 1'b0);
    chk("r_idle_pc", PC, 10'd0);
    @(negedge clk);
    run_instr(tbl[0], 0);

    // Run up to the last word and check the PC wraps to 0
    repeat (4 * 1022) @(negedge clk);
    chk("wrap_pc_top", PC, 10'd1023);
    chk("wrap_fetch_top", IM_read, 1'b1);
    run_instr(nop_rec, 1023);
    chk("wrap_pc0", PC, 10'd0);
    run_instr(tbl[0], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
